nfc_acg_arbiter: RTL and testbench
==================================

// Module: nfc_acg_arbiter
// PURPOSE
//  Shares the single atomic command generator (ACG) among NumberOfCmds command
//  sequencers (read page, program page, erase, reset, features, ...). On a start
//  pulse it grants the ACG to the issuing sequencer, muxes that sequencer's ACG
//  request bus onto the ACG and routes ACG status back to it. It releases the grant
//  on the owner's last step, or on a watchdog timeout. Sits between the command
//  sequencers and the ACG.
// PARAMETERS
//  NumberOfWays   4        width of the way-select / ready-busy vectors
//  NumberOfCmds   4        number of sequencers (requesters), 2..8
//  TimeoutCycles  24'hFFFFFF  watchdog limit in ACTIVE; 0 disables the watchdog
// PORTS
//  iSystemClock      in   1        system clock
//  iReset            in   1        synchronous reset, active high
//  iCmd_Start        in   N        per-sequencer start pulse (opcode decoded AND CMDValid)
//  iCmd_LastStep     in   N        per-sequencer last-step flag
//  iCmd_ACG_Command  in   8*N      packed command vectors; slice i = [8i+7:8i]
//  iCmd_ACG_CmdOpt   in   3*N      packed command options
//  iCmd_ACG_TargetWay in  NW*N     packed target-way vectors
//  iCmd_ACG_NumOfData in  16*N     packed data counts
//  iCmd_ACG_CASelect in   N        packed CA select bits
//  iCmd_ACG_CAData   in   40*N     packed CA data
//  oCmd_ACG_Ready    out  8*N      ACG ready, routed to the owner only; other slices are 0
//  oCmd_ACG_LastStep out  8*N      ACG last step, routed to the owner only; other slices are 0
//  iACG_Ready        in   8        from ACG
//  iACG_LastStep     in   8        from ACG
//  oACG_Command      out  8        to ACG
//  oACG_CommandOption out 3        to ACG
//  oACG_TargetWay    out  NW       to ACG
//  oACG_NumOfData    out  16       to ACG
//  oACG_CASelect     out  1        to ACG
//  oACG_CAData       out  40       to ACG
//  oCMDReady         out  1        high = arbiter idle, host may issue a command
//  oOwner            out  3        index of the current owner (0 when idle)
//  oTimeout          out  1        one-cycle pulse when the watchdog fires
//  oConflict         out  1        sticky: start seen while busy or multiple starts; cleared by reset
// BEHAVIOUR
//  Reset: state=IDLE; oCMDReady=1; oOwner=0; oTimeout=0; oConflict=0; counter=0.
//   All oACG_* outputs are 0, except oACG_CASelect=1.
//  States:
//   IDLE -> ACTIVE when |iCmd_Start. Owner = lowest set index. If more than one bit is
//    set, oConflict<=1.
//   ACTIVE -> IDLE on iCmd_LastStep[owner]=1, or when the counter reaches TimeoutCycles.
//  Latency: a start sampled at edge k gives registered owner/state from cycle k+1.
//   oCMDReady=0 from k+1. oACG_* = combinational mux of the owner slice from k+1.
//  Release: LastStep seen at edge m -> IDLE from m+1. oCMDReady=1 at m+1.
//   A new start is accepted no earlier than edge m+1.
//  IDLE outputs: oACG_* at reset values. All oCmd_ACG_* slices are 0.
//  ACTIVE routing:
//   - oCmd_ACG_Ready[owner]    = iACG_Ready
//   - oCmd_ACG_LastStep[owner] = iACG_LastStep
//   - all other slices are 0, so a non-owner never sees ACG ready.
//  Start in ACTIVE (any index, including the owner) is ignored and sets oConflict.
//  Watchdog: a 24-bit counter clears on entering ACTIVE and increments each ACTIVE
//   cycle. When counter==TimeoutCycles-1 (and TimeoutCycles!=0):
//   - oTimeout=1 for the next cycle;
//   - state -> IDLE.
//   LastStep arriving in that same cycle takes priority; no timeout is flagged.
//  LastStep from a non-owner is ignored.
//  Synchronous reset mid-ACTIVE: back to reset values next edge; the grant is dropped
//   immediately.
// TESTING
//  1 Reset, then iCmd_Start=4'b0100 for 1 cycle -> next cycle oOwner=2, oCMDReady=0,
//    oACG_Command equals slice 2 (e.g. 8'h08), oCmd_ACG_Ready[23:16]=iACG_Ready, other slices 0.
//  2 Owner 2 asserts LastStep at edge m -> at m+1 oCMDReady=1, oACG_Command=0,
//    oACG_CASelect=1; a start at m+1 for index 0 is granted at m+2.
//  3 iCmd_Start=4'b1010 in IDLE -> oOwner=1, oConflict=1; index 3 is never routed ACG ready.
//  4 TimeoutCycles=16, owner never finishes -> oTimeout pulses exactly 16 cycles after
//    the grant; the following cycle is IDLE.
//  5 Start for index 3 while owner 0 is ACTIVE -> grant unchanged, oConflict=1,
//    oACG_* still shows slice 0.
//  6 iReset=1 for one cycle mid-ACTIVE -> next cycle all outputs at reset values, oConflict=0.

Source files
------------

// File: rtl/nfc_acg_arbiter.sv
// Grants the single atomic command generator to one of several command sequencers,
// muxes the owner's request bus onto the ACG and routes ACG status back to it.
module nfc_acg_arbiter #(
    parameter int          NumberOfWays  = 4,
    parameter int          NumberOfCmds  = 4,
    parameter logic [23:0] TimeoutCycles = 24'hFFFFFF
) (
    input  logic                                 iSystemClock,
    input  logic                                 iReset,
    input  logic [NumberOfCmds-1:0]              iCmd_Start,
    input  logic [NumberOfCmds-1:0]              iCmd_LastStep,
    input  logic [8*NumberOfCmds-1:0]            iCmd_ACG_Command,
    input  logic [3*NumberOfCmds-1:0]            iCmd_ACG_CmdOpt,
    input  logic [NumberOfWays*NumberOfCmds-1:0] iCmd_ACG_TargetWay,
    input  logic [16*NumberOfCmds-1:0]           iCmd_ACG_NumOfData,
    input  logic [NumberOfCmds-1:0]              iCmd_ACG_CASelect,
    input  logic [40*NumberOfCmds-1:0]           iCmd_ACG_CAData,
    output logic [8*NumberOfCmds-1:0]            oCmd_ACG_Ready,
    output logic [8*NumberOfCmds-1:0]            oCmd_ACG_LastStep,
    input  logic [7:0]                           iACG_Ready,
    input  logic [7:0]                           iACG_LastStep,
    output logic [7:0]                           oACG_Command,
    output logic [2:0]                           oACG_CommandOption,
    output logic [NumberOfWays-1:0]              oACG_TargetWay,
    output logic [15:0]                          oACG_NumOfData,
    output logic                                 oACG_CASelect,
    output logic [39:0]                          oACG_CAData,
    output logic                                 oCMDReady,
    output logic [2:0]                           oOwner,
    output logic                                 oTimeout,
    output logic                                 oConflict
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [23:0] TIMEOUT_LAST = TimeoutCycles - 24'd1;
    localparam logic        WD_ENABLE    = (TimeoutCycles != 24'd0);

    state_t      state_reg, state_next;
    logic [2:0]  owner_reg, owner_next;
    logic [23:0] counter_reg, counter_next;
    logic        timeout_reg, timeout_next;
    logic        conflict_reg, conflict_next;

    logic        active;
    logic [7:0]  start_pad, last_pad, casel_pad;
    logic [2:0]  grant_idx;
    logic        multi_start;

    // Per-requester slices padded to 8 entries so a 3-bit owner indexes cleanly.
    logic [7:0]              cmd_arr   [0:7];
    logic [2:0]              opt_arr   [0:7];
    logic [NumberOfWays-1:0] way_arr   [0:7];
    logic [15:0]             num_arr   [0:7];
    logic [39:0]             ca_arr    [0:7];

    assign active    = (state_reg == ACTIVE);
    assign start_pad = 8'(iCmd_Start);
    assign last_pad  = 8'(iCmd_LastStep);
    assign casel_pad = 8'(iCmd_ACG_CASelect);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            if (gi < NumberOfCmds) begin : g_used
                assign cmd_arr[gi] = iCmd_ACG_Command[8*gi +: 8];
                assign opt_arr[gi] = iCmd_ACG_CmdOpt[3*gi +: 3];
                assign way_arr[gi] = iCmd_ACG_TargetWay[NumberOfWays*gi +: NumberOfWays];
                assign num_arr[gi] = iCmd_ACG_NumOfData[16*gi +: 16];
                assign ca_arr[gi]  = iCmd_ACG_CAData[40*gi +: 40];
                // Only the owner ever sees ACG status; everyone else reads zero.
                assign oCmd_ACG_Ready[8*gi +: 8] =
                    (active && owner_reg == 3'(gi)) ? iACG_Ready : 8'h00;
                assign oCmd_ACG_LastStep[8*gi +: 8] =
                    (active && owner_reg == 3'(gi)) ? iACG_LastStep : 8'h00;
            end else begin : g_pad
                assign cmd_arr[gi] = '0;
                assign opt_arr[gi] = '0;
                assign way_arr[gi] = '0;
                assign num_arr[gi] = '0;
                assign ca_arr[gi]  = '0;
            end
        end
    endgenerate

    always_comb begin
        grant_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (start_pad[i]) grant_idx = 3'(i);
        end
    end

    assign multi_start = ((start_pad & (start_pad - 8'd1)) != 8'd0);

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        counter_next  = counter_reg;
        timeout_next  = 1'b0;
        conflict_next = conflict_reg;
        case (state_reg)
            IDLE: begin
                counter_next = 24'd0;
                if (|start_pad) begin
                    state_next = ACTIVE;
                    owner_next = grant_idx;
                    if (multi_start) conflict_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (|start_pad) conflict_next = 1'b1;
                // Owner's last step wins over a watchdog expiry in the same cycle.
                if (last_pad[owner_reg]) begin
                    state_next   = IDLE;
                    owner_next   = 3'd0;
                    counter_next = 24'd0;
                end else if (WD_ENABLE && counter_reg == TIMEOUT_LAST) begin
                    state_next   = IDLE;
                    owner_next   = 3'd0;
                    counter_next = 24'd0;
                    timeout_next = 1'b1;
                end else begin
                    counter_next = counter_reg + 24'd1;
                end
            end
            default: begin
                state_next = IDLE;
                owner_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_reg    <= IDLE;
            owner_reg    <= 3'd0;
            counter_reg  <= 24'd0;
            timeout_reg  <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            counter_reg  <= counter_next;
            timeout_reg  <= timeout_next;
            conflict_reg <= conflict_next;
        end
    end

    assign oACG_Command       = active ? cmd_arr[owner_reg]   : 8'h00;
    assign oACG_CommandOption = active ? opt_arr[owner_reg]   : 3'd0;
    assign oACG_TargetWay     = active ? way_arr[owner_reg]   : '0;
    assign oACG_NumOfData     = active ? num_arr[owner_reg]   : 16'h0000;
    assign oACG_CASelect      = active ? casel_pad[owner_reg] : 1'b1;
    assign oACG_CAData        = active ? ca_arr[owner_reg]    : 40'h0;
    assign oCMDReady          = ~active;
    assign oOwner             = owner_reg;
    assign oTimeout           = timeout_reg;
    assign oConflict          = conflict_reg;

endmodule

// File: tb/tb_nfc_acg_arbiter.sv
// Directed bench for nfc_acg_arbiter: grant, release, conflicts, watchdog and reset.
module tb_nfc_acg_arbiter;

    localparam int NW = 4;
    localparam int N  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      start, last;
    logic [8*N-1:0]    cmd;
    logic [3*N-1:0]    opt;
    logic [NW*N-1:0]   way;
    logic [16*N-1:0]   num;
    logic [N-1:0]      casel;
    logic [40*N-1:0]   cadata;
    logic [8*N-1:0]    cmd_ready, cmd_last;
    logic [7:0]        acg_ready, acg_last;
    logic [7:0]        acg_cmd;
    logic [2:0]        acg_opt;
    logic [NW-1:0]     acg_way;
    logic [15:0]       acg_num;
    logic              acg_casel;
    logic [39:0]       acg_ca;
    logic              cmdready, tmo, conflict;
    logic [2:0]        owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nfc_acg_arbiter #(.NumberOfWays(NW), .NumberOfCmds(N), .TimeoutCycles(24'd16)) dut (
        .iSystemClock(clk), .iReset(rst),
        .iCmd_Start(start), .iCmd_LastStep(last),
        .iCmd_ACG_Command(cmd), .iCmd_ACG_CmdOpt(opt), .iCmd_ACG_TargetWay(way),
        .iCmd_ACG_NumOfData(num), .iCmd_ACG_CASelect(casel), .iCmd_ACG_CAData(cadata),
        .oCmd_ACG_Ready(cmd_ready), .oCmd_ACG_LastStep(cmd_last),
        .iACG_Ready(acg_ready), .iACG_LastStep(acg_last),
        .oACG_Command(acg_cmd), .oACG_CommandOption(acg_opt), .oACG_TargetWay(acg_way),
        .oACG_NumOfData(acg_num), .oACG_CASelect(acg_casel), .oACG_CAData(acg_ca),
        .oCMDReady(cmdready), .oOwner(owner), .oTimeout(tmo), .oConflict(conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 64'(cmdready), 64'd1);
        chk({tag, ".owner"}, 64'(owner), 64'd0);
        chk({tag, ".cmd"}, 64'(acg_cmd), 64'd0);
        chk({tag, ".casel"}, 64'(acg_casel), 64'd1);
        chk({tag, ".ca"}, 64'(acg_ca), 64'd0);
        chk({tag, ".route"}, 64'(cmd_ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = '0; last = '0;
        cmd    = {8'h0B, 8'h08, 8'h05, 8'h02};
        opt    = {3'd4, 3'd3, 3'd2, 3'd1};
        way    = 16'h8421;
        num    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        casel  = 4'b0110;
        cadata = {40'h44_0000_0004, 40'h33_0000_0003, 40'h22_0000_0002, 40'h11_0000_0001};
        acg_ready = 8'hA5; acg_last = 8'h3C;

        tick(); tick();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset.timeout", 64'(tmo), 64'd0);
        chk("reset.conflict", 64'(conflict), 64'd0);
        chk("reset.lastroute", 64'(cmd_last), 64'd0);
        $display("txn reset done");

        // Grant to index 2
        start = 4'b0100; tick(); start = '0;
        chk("t1.owner", 64'(owner), 64'd2);
        chk("t1.ready", 64'(cmdready), 64'd0);
        chk("t1.cmd", 64'(acg_cmd), 64'h08);
        chk("t1.opt", 64'(acg_opt), 64'd3);
        chk("t1.way", 64'(acg_way), 64'h4);
        chk("t1.num", 64'(acg_num), 64'h3333);
        chk("t1.casel", 64'(acg_casel), 64'd1);
        chk("t1.route", 64'(cmd_ready), 64'h00A5_0000);
        chk("t1.lastroute", 64'(cmd_last), 64'h003C_0000);
        chk("t1.conflict", 64'(conflict), 64'd0);
        $display("txn grant idx2 owner=%0d", owner);

        // Non-owner last step ignored, then owner releases
        last = 4'b0001; tick(); last = '0;
        chk("t2.nonowner", 64'(owner), 64'd2);
        chk("t2.nonowner_busy", 64'(cmdready), 64'd0);
        last = 4'b0100; tick(); last = '0;
        chk_idle("t2.release");
        start = 4'b0001; tick(); start = '0;
        chk("t2.regrant_owner", 64'(owner), 64'd0);
        chk("t2.regrant_cmd", 64'(acg_cmd), 64'h02);
        chk("t2.regrant_casel", 64'(acg_casel), 64'd0);
        chk("t2.regrant_conflict", 64'(conflict), 64'd0);
        $display("txn release then grant idx0 owner=%0d", owner);

        // Start while busy
        start = 4'b1000; tick(); start = '0;
        chk("t5.owner", 64'(owner), 64'd0);
        chk("t5.conflict", 64'(conflict), 64'd1);
        chk("t5.cmd", 64'(acg_cmd), 64'h02);
        chk("t5.ca", 64'(acg_ca), 64'h11_0000_0001);
        $display("txn busy start idx3 conflict=%0d", conflict);

        // Reset mid-ACTIVE
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle("t6");
        chk("t6.conflict", 64'(conflict), 64'd0);
        chk("t6.timeout", 64'(tmo), 64'd0);
        $display("txn reset mid-active");

        // Simultaneous starts: lowest wins, index 3 never routed
        acg_ready = 8'hFF;
        start = 4'b1010; tick(); start = '0;
        chk("t3.owner", 64'(owner), 64'd1);
        chk("t3.conflict", 64'(conflict), 64'd1);
        chk("t3.route", 64'(cmd_ready), 64'h0000_FF00);
        chk("t3.cmd", 64'(acg_cmd), 64'h05);
        last = 4'b0010; tick(); last = '0;
        chk_idle("t3.release");
        $display("txn multi-start owner=1");

        // Watchdog expiry 16 cycles after grant
        start = 4'b0001; tick(); start = '0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("t4.no_timeout", 64'(tmo), 64'd0);
            chk("t4.busy", 64'(cmdready), 64'd0);
        end
        tick();
        chk("t4.timeout", 64'(tmo), 64'd1);
        chk_idle("t4.idle");
        tick();
        chk("t4.pulse_end", 64'(tmo), 64'd0);
        chk("t4.still_idle", 64'(cmdready), 64'd1);
        $display("txn watchdog expiry");

        // Last step on the expiry cycle takes priority
        start = 4'b0100; tick(); start = '0;
        for (int i = 1; i <= 15; i++) tick();
        chk("t4b.busy", 64'(cmdready), 64'd0);
        last = 4'b0100; tick(); last = '0;
        chk("t4b.no_timeout", 64'(tmo), 64'd0);
        chk("t4b.released", 64'(cmdready), 64'd1);
        $display("txn laststep beats watchdog");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
